// File: rtl/ms_timer_ctrl.sv
// ms_timer_ctrl
// Millisecond timer controller. A 16-bit prescaler turns clk_in into
// millisecond ticks. The remaining counter counts down a latched period of
// ticks. A run is either one-shot or auto-reloading (periodic). It can be
// frozen with hold, cancelled with abort, or cleared with rst. Every output
// comes straight from a register.
//
// Ports
//   clk_in     in   system clock, rising-edge active
//   rst        in   synchronous active-high reset
//   start      in   begin a run; only looked at while IDLE
//   abort      in   cancel the run; highest priority after rst
//   hold       in   level; freezes an active run while high
//   periodic   in   1 = auto-reload, 0 = one-shot; latched at start
//   period_ms  in   run length in ticks; latched at start
//   busy       out  high while in RUN or HOLD
//   tick_ms    out  one-cycle pulse per elapsed tick
//   expire     out  one-cycle pulse when the remaining count reaches zero
//   sq_out     out  toggles on every expire
//   err        out  one-cycle pulse on a start with period_ms == 0
//   remaining  out  ticks left in the current period
//   state      out  IDLE=00, RUN=01, HOLD=10
module ms_timer_ctrl #(
    parameter int unsigned PRESCALE = 40000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic             periodic,
    input  logic [CNT_W-1:0] period_ms,
    output logic             busy,
    output logic             tick_ms,
    output logic             expire,
    output logic             sq_out,
    output logic             err,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [15:0]      PRE_MAX = 16'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [15:0]      pre_q, pre_d;
    logic [CNT_W-1:0] rem_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             periodic_q, periodic_d;
    logic             tick_d, expire_d, sq_d, err_d, busy_d;

    logic active;
    logic count_en;
    logic wrap;
    logic final_tick;
    logic start_ok;

    // Counting only advances on edges where the run is active and hold is
    // low. So the edge that leaves HOLD already counts, which makes the
    // elapsed time grow by exactly the number of held edges. A hold on the
    // wrap edge therefore suppresses the tick.
    assign active     = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign count_en   = active && !hold;
    assign wrap       = count_en && (pre_q == PRE_MAX);
    assign final_tick = wrap && (remaining == REM_ONE);
    assign start_ok   = (state_q == ST_IDLE) && start && (period_ms != '0);

    assign state = state_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort overrides everything in every state. A one-shot run returns to
    // IDLE on its final tick. A periodic run stays in RUN.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (hold) begin
                        state_d = ST_HOLD;
                    end else if (final_tick && !periodic_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next values for the datapath and the registered outputs. remaining is
    // only decremented from a non-zero value, so it can never wrap. On the
    // final tick it reloads (periodic) or clears (one-shot) instead.
    always_comb begin
        pre_d      = pre_q;
        rem_d      = remaining;
        period_d   = period_q;
        periodic_d = periodic_q;
        tick_d     = 1'b0;
        expire_d   = 1'b0;
        sq_d       = sq_out;
        err_d      = 1'b0;
        if (abort) begin
            pre_d = '0;
            rem_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (start_ok) begin
                period_d   = period_ms;
                periodic_d = periodic;
                rem_d      = period_ms;
                pre_d      = '0;
            end else if (start) begin
                err_d = 1'b1;
            end
        end else if (count_en) begin
            if (wrap) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (final_tick) begin
                    expire_d = 1'b1;
                    sq_d     = ~sq_out;
                    rem_d    = periodic_q ? period_q : '0;
                end else if (remaining != '0) begin
                    rem_d = remaining - REM_ONE;
                end
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pre_q      <= '0;
            remaining  <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tick_ms    <= 1'b0;
            expire     <= 1'b0;
            sq_out     <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            remaining  <= rem_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            tick_ms    <= tick_d;
            expire     <= expire_d;
            sq_out     <= sq_d;
            err        <= err_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ms_timer_ctrl.sv
// Testbench for ms_timer_ctrl, using PRESCALE=4.
// Directed scenarios are checked against timing values written out by hand.
// A randomized run is checked against an elapsed-time reference model.
module tb_ms_timer_ctrl;

    localparam int P = 4;
    localparam int W = 16;

    logic         clk_in = 1'b0;
    logic         rst, start, abort, hold, periodic;
    logic [W-1:0] period_ms;
    logic         busy, tick_ms, expire, sq_out, err;
    logic [W-1:0] remaining;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;

    // Reference model state. The model tracks how many counted cycles have
    // elapsed since start (phase). Ticks, expiries and remaining are then
    // derived from phase with plain arithmetic.
    bit m_active, m_held, m_mode, m_tick, m_exp, m_sq, m_err;
    int m_n, m_phase, m_rem;

    ms_timer_ctrl #(.PRESCALE(P), .CNT_W(W)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .hold      (hold),
        .periodic  (periodic),
        .period_ms (period_ms),
        .busy      (busy),
        .tick_ms   (tick_ms),
        .expire    (expire),
        .sq_out    (sq_out),
        .err       (err),
        .remaining (remaining),
        .state     (state)
    );

    always #5 clk_in = ~clk_in;

    function automatic void model_edge();
        if (rst) begin
            m_active = 0; m_held = 0; m_mode = 0; m_tick = 0; m_exp = 0;
            m_sq = 0; m_err = 0; m_rem = 0; m_phase = 0; m_n = 0;
        end else if (abort) begin
            m_active = 0; m_held = 0; m_rem = 0;
            m_tick = 0; m_exp = 0; m_err = 0;
        end else if (!m_active) begin
            m_tick = 0; m_exp = 0;
            m_err = start && (period_ms == 0);
            if (start && period_ms != 0) begin
                m_active = 1; m_held = 0; m_n = int'(period_ms);
                m_mode = periodic; m_phase = 0; m_rem = m_n;
            end
        end else begin
            m_err = 0;
            if (hold) begin
                m_held = 1; m_tick = 0; m_exp = 0;
            end else begin
                m_held = 0;
                m_phase++;
                m_tick = (m_phase % P) == 0;
                m_exp  = m_tick && ((m_phase % (m_n * P)) == 0);
                if (m_exp) m_sq = !m_sq;
                if (m_exp && !m_mode) begin
                    m_active = 0;
                    m_rem    = 0;
                end else begin
                    m_rem = m_n - ((m_phase / P) % m_n);
                end
            end
        end
    endfunction

    // Advance one clock edge: the model sees the same inputs the DUT samples.
    // Outputs are then read 1ns later.
    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1; start = 0; abort = 0; hold = 0;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({busy, tick_ms, expire, sq_out, err, remaining, state} !== '0) begin
            bad++;
            $display("[TB] FAIL reset: got busy=%b tick=%b exp=%b sq=%b err=%b rem=%0d state=%b, want all 0",
                     busy, tick_ms, expire, sq_out, err, remaining, state);
        end
    endtask

    task automatic test_one_shot();
        logic [W-1:0] e_rem;
        apply_reset();
        period_ms = 3; periodic = 0; start = 1;
        step();
        start = 0;
        total++;
        if (busy !== 1'b1 || state !== 2'b01 || remaining !== 16'd3) begin
            bad++;
            $display("[TB] FAIL one_shot_start: got busy=%b state=%b rem=%0d, want 1 01 3",
                     busy, state, remaining);
        end
        for (int c = 1; c <= 12; c++) begin
            step();
            e_rem = (c < 4) ? 16'd3 : (c < 8) ? 16'd2 : (c < 12) ? 16'd1 : 16'd0;
            total++;
            if ({tick_ms, expire, busy, sq_out, remaining} !==
                {(c % 4) == 0, c == 12, c < 12, c >= 12, e_rem}) begin
                bad++;
                $display("[TB] FAIL one_shot c=%0d: got tick=%b exp=%b busy=%b sq=%b rem=%0d, want %b %b %b %b %0d",
                         c, tick_ms, expire, busy, sq_out, remaining,
                         (c % 4) == 0, c == 12, c < 12, c >= 12, e_rem);
            end
        end
    endtask

    task automatic test_periodic();
        logic [W-1:0] e_rem;
        apply_reset();
        period_ms = 2; periodic = 1; start = 1;
        step();
        start = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            e_rem = W'(2 - ((c / 4) % 2));
            total++;
            if ({expire, tick_ms, busy, sq_out, remaining} !==
                {(c % 8) == 0, (c % 4) == 0, 1'b1, ((c / 8) % 2) == 1, e_rem}) begin
                bad++;
                $display("[TB] FAIL periodic c=%0d: got exp=%b tick=%b busy=%b sq=%b rem=%0d, want %b %b 1 %b %0d",
                         c, expire, tick_ms, busy, sq_out, remaining,
                         (c % 8) == 0, (c % 4) == 0, ((c / 8) % 2) == 1, e_rem);
            end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        period_ms = 2; periodic = 0; start = 1;
        step();
        start = 0;
        step();
        hold = 1;
        for (int c = 2; c <= 6; c++) begin
            step();
            total++;
            if (state !== 2'b10 || tick_ms !== 1'b0 || expire !== 1'b0 || remaining !== 16'd2) begin
                bad++;
                $display("[TB] FAIL hold c=%0d: got state=%b tick=%b exp=%b rem=%0d, want 10 0 0 2",
                         c, state, tick_ms, expire, remaining);
            end
        end
        hold = 0;
        for (int c = 7; c <= 13; c++) begin
            step();
            total++;
            if ({expire, tick_ms, state} !==
                {c == 13, c == 9 || c == 13, (c == 13) ? 2'b00 : 2'b01}) begin
                bad++;
                $display("[TB] FAIL hold_resume c=%0d: got exp=%b tick=%b state=%b, want exp=%b",
                         c, expire, tick_ms, state, c == 13);
            end
        end
    endtask

    task automatic test_abort_final();
        apply_reset();
        period_ms = 1; periodic = 0; start = 1;
        step();
        start = 0;
        for (int c = 1; c <= 3; c++) step();
        abort = 1;
        step();
        abort = 0;
        total++;
        if ({expire, tick_ms, busy, sq_out, state, remaining} !== '0) begin
            bad++;
            $display("[TB] FAIL abort_final: got exp=%b tick=%b busy=%b sq=%b state=%b rem=%0d, want all 0",
                     expire, tick_ms, busy, sq_out, state, remaining);
        end
        start = 1; abort = 1; period_ms = 3;
        step();
        start = 0; abort = 0;
        total++;
        if ({busy, err, state} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL abort_start: got busy=%b err=%b state=%b, want 0 0 00",
                     busy, err, state);
        end
    endtask

    task automatic test_reject();
        logic [W-1:0] e_rem;
        apply_reset();
        period_ms = 0; start = 1;
        step();
        start = 0;
        total++;
        if ({err, busy, state} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL reject: got err=%b busy=%b state=%b, want 1 0 00", err, busy, state);
        end
        step();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reject_pulse: got err=%b, want 0", err);
        end
        period_ms = 2; periodic = 0; start = 1;
        step();
        for (int c = 1; c <= 8; c++) begin
            start = (c == 2);
            period_ms = 5; periodic = 1;
            step();
            e_rem = (c < 4) ? 16'd2 : (c < 8) ? 16'd1 : 16'd0;
            total++;
            if ({err, expire, busy, remaining} !== {1'b0, c == 8, c < 8, e_rem}) begin
                bad++;
                $display("[TB] FAIL start_in_run c=%0d: got err=%b exp=%b busy=%b rem=%0d, want 0 %b %b %0d",
                         c, err, expire, busy, remaining, c == 8, c < 8, e_rem);
            end
        end
        start = 0;
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        period_ms = 2; periodic = 1; start = 1;
        step();
        start = 0;
        for (int c = 1; c <= 5; c++) step();
        rst = 1;
        step();
        rst = 0;
        total++;
        if ({busy, tick_ms, expire, sq_out, err, remaining, state} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid_run: got busy=%b tick=%b exp=%b sq=%b err=%b rem=%0d state=%b, want all 0",
                     busy, tick_ms, expire, sq_out, err, remaining, state);
        end
        period_ms = 3; periodic = 0; start = 1;
        step();
        start = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            total++;
            if ({tick_ms, expire, busy} !== {(c % 4) == 0, c == 12, c < 12}) begin
                bad++;
                $display("[TB] FAIL restart c=%0d: got tick=%b exp=%b busy=%b, want %b %b %b",
                         c, tick_ms, expire, busy, (c % 4) == 0, c == 12, c < 12);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]   e_state;
        logic [W-1:0] e_rem;
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 699) == 0);
            start     = ($urandom_range(0, 5) == 0);
            abort     = ($urandom_range(0, 79) == 0);
            hold      = ($urandom_range(0, 4) == 0) ? !hold : hold;
            periodic  = 1'($urandom_range(0, 1));
            period_ms = W'($urandom_range(0, 4));
            step();
            e_state = !m_active ? 2'b00 : (m_held ? 2'b10 : 2'b01);
            e_rem   = W'(m_rem);
            total++;
            if ({busy, tick_ms, expire, sq_out, err, remaining, state} !==
                {m_active, m_tick, m_exp, m_sq, m_err, e_rem, e_state}) begin
                bad++;
                $display("[TB] FAIL random i=%0d: got busy=%b tick=%b exp=%b sq=%b err=%b rem=%0d state=%b, want %b %b %b %b %b %0d %b",
                         i, busy, tick_ms, expire, sq_out, err, remaining, state,
                         m_active, m_tick, m_exp, m_sq, m_err, e_rem, e_state);
            end
        end
        rst = 0; start = 0; abort = 0; hold = 0;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; hold = 0; periodic = 0; period_ms = '0;
        $display("[TB] starting ms_timer_ctrl bench");
        test_reset();
        test_one_shot();
        test_periodic();
        test_hold();
        test_abort_final();
        test_reject();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ms_timer_ctrl.md
MS_TIMER_CTRL -- requirements
Module: ms_timer_ctrl

Interface
REQ-001 Parameter PRESCALE, default 40000, clk_in cycles per millisecond tick (40 MHz in); legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, width of the period and remaining counters.
REQ-003 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin a timing run; sampled only in IDLE.
REQ-006 abort  input  1  cancel the current run; highest priority after rst.
REQ-007 hold  input  1  level; freezes an active run while high.
REQ-008 periodic  input  1  mode, latched at start: 1 = auto-reload, 0 = one-shot.
REQ-009 period_ms  input  CNT_W  run length in ticks, latched at start.
REQ-010 busy  output  1  high in RUN or HOLD.
REQ-011 tick_ms  output  1  one-cycle pulse per elapsed tick.
REQ-012 expire  output  1  one-cycle pulse when the remaining count reaches 0.
REQ-013 sq_out  output  1  toggles on every expire (square wave in periodic mode).
REQ-014 err  output  1  one-cycle pulse on a rejected start.
REQ-015 remaining  output  CNT_W  ticks left in the current period.
REQ-016 state  output  2  IDLE=00, RUN=01, HOLD=10; 11 unused.

Function
REQ-017 All outputs SHALL be registered; internal prescaler pre is 16 bits.
REQ-018 IDLE, start=1, period_ms!=0: SHALL latch period_ms and periodic, set remaining=period_ms, set pre=0, and enter RUN.
REQ-019 IDLE, start=1, period_ms==0: SHALL pulse err for one cycle and remain in IDLE.
REQ-020 start in RUN or HOLD SHALL be ignored, with no err pulse.
REQ-021 RUN, pre!=PRESCALE-1: SHALL increment pre and drive tick_ms=0.
REQ-022 RUN, pre==PRESCALE-1: SHALL set pre=0, pulse tick_ms, and decrement remaining.
REQ-023 Final tick (remaining==1 at that edge): SHALL pulse expire and toggle sq_out in the same cycle as tick_ms.
REQ-024 After the final tick, one-shot mode SHALL enter IDLE with remaining=0 and busy=0.
REQ-025 After the final tick, periodic mode SHALL reload remaining from the latched period and stay in RUN.
REQ-026 Latency: first tick_ms SHALL be high exactly PRESCALE cycles after the start edge.
REQ-027 Latency: expire SHALL be high N*PRESCALE cycles after the start edge, where N is the latched period.
REQ-028 RUN with hold=1: SHALL enter HOLD; pre and remaining frozen; no tick or expire.
REQ-029 HOLD with hold=0: SHALL return to RUN and resume from the frozen pre value.
REQ-030 Elapsed time SHALL extend by exactly the number of held cycles.
REQ-031 hold and a wrap on the same edge: hold wins; no tick; pre stays at PRESCALE-1.
REQ-032 abort=1 in any state: SHALL go to IDLE with remaining=0, pre=0, and no tick or expire.
REQ-033 abort coincident with the final tick: abort wins; expire=0; sq_out unchanged.
REQ-034 abort and start on the same edge from IDLE: abort wins; no run begins.
REQ-035 Changes to period_ms or periodic during a run SHALL take effect only at the next start.
REQ-036 Counters SHALL never wrap below 0; remaining decrements only from values >=1.

Reset
REQ-037 rst=1 at a clock edge SHALL force state=IDLE and clear pre, remaining, busy, tick_ms, expire, sq_out and err.
REQ-038 rst SHALL override abort, start and hold.
REQ-039 rst mid-run SHALL lose the run, with no expire pulse.

Verification (PRESCALE=4 for simulation)
REQ-040 One-shot run:
- Stimulus: start with period=3, periodic=0.
- Response: tick_ms at cycles 4, 8, 12 after the start edge; remaining 3→2→1→0; expire and busy fall at cycle 12; sq_out 0→1.
REQ-041 Periodic run:
- Stimulus: periodic=1, period=2, run 40 cycles.
- Response: expire at cycles 8, 16, 24, 32, 40; sq_out toggles at each; remaining reloads to 2; busy stays 1.
REQ-042 Hold:
- Stimulus: period=2; hold high for 5 cycles starting at cycle 2.
- Response: state=HOLD throughout; expire at cycle 13 instead of 8.
REQ-043 Abort at final tick:
- Stimulus: period=1; abort asserted on the cycle-4 edge.
- Response: expire=0, state=IDLE, remaining=0, sq_out unchanged.
REQ-044 Rejected start:
- Stimulus: start with period=0 in IDLE.
- Response: err high for exactly 1 cycle; busy stays 0.
- Stimulus: start during RUN.
- Response: no err; timing unaffected.
REQ-045 Reset mid-run:
- Stimulus: rst at cycle 6 of a periodic run.
- Response: every output 0 and state=00 on the next cycle; a new start behaves as in REQ-040.
